adder_tree_acc: RTL
===================

# adder_tree_acc

Parametrised, back-pressurable, pipelined adder tree with a beat accumulator for the int8 vector-MAC datapath. It reduces LANES partial products per beat, signed or unsigned, and accumulates successive beats until a last-beat marker. It then emits one dot-product result with an overflow flag and a beat count. It sits between the lane multiplier array and the result FIFO, and lets vectors longer than LANES be handled in multiple beats.

## Interface
- LANES, 4, lane count; power of 2, 1..64
- INW, 16, width of each partial product
- SIGNED, 1, 1 = two's-complement operands/results, 0 = unsigned
- SAT, 0, 1 = accumulator saturates on overflow, 0 = wraps
- ACCW, INW+$clog2(LANES)+8, accumulator/result width; must be ≥ INW+$clog2(LANES)
- CNTW, 8, beat counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all in-flight data and accumulator
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  beat is last of current vector
- prod_flat  in  LANES*INW  lane i at [INW*i +: INW]
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_sum  out  ACCW  accumulated dot product
- out_ovf  out  1  accumulator overflowed at least once in this vector
- out_beats  out  CNTW  number of beats in this vector (saturates at 2^CNTW-1)

## Operation
- Tree width TW = INW+$clog2(LANES). Operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to TW before the first add. Extension never drops a carry.
- Tree levels: D = $clog2(LANES) pairwise reduction levels, each registered. LANES=1 uses a single pass-through register level. Tree stages TS = max(1, D).
- Valid and last bits travel alongside the tree registers, TS deep.
- Accumulate stage, on a tree-output beat:
  - First beat of a vector (acc_empty=1): acc ← ext(tree), cnt ← 1, ovf ← 0.
  - Otherwise: acc ← acc + ext(tree), cnt ← cnt+1 (saturating), ovf ← ovf | overflow.
- Overflow is detected in ACCW+1 bits: signed range for SIGNED=1, carry-out for SIGNED=0.
  - SAT=1: clamp to the ACCW max or min.
  - SAT=0: wrap.
  - In both cases the flag is set.
- Last beat: the new acc/ovf/cnt are copied into the output register, out_valid ← 1, acc_empty ← 1. The accumulator becomes free for the next vector in the same cycle.
- Single-beat vector (in_last on the first beat): out_sum = tree sum.
- Back-pressure is a global stall: adv = !(out_valid && !out_ready); in_ready = adv.
  - Every pipeline, accumulator and output register updates only when adv=1.
  - The output register loads a new result only when adv=1. Results are never overwritten or lost.
- flush=1 has priority over everything else:
  - clears valid bits, acc, cnt, ovf and out_valid; sets acc_empty=1.
  - A beat presented in the flush cycle is dropped.
- Reset: all registers 0, acc_empty=1, out_valid=0, in_ready=1, out_sum/out_ovf/out_beats=0.
- A mid-vector reset or flush discards the partial vector. No result is emitted for it.

## Timing
- Latency from an accepted last beat to out_valid is TS+1 cycles when not stalled. LANES=4 gives 3; LANES=64 gives 7.
- Throughput is one beat per cycle. Back-to-back vectors produce no bubble.
- out_valid, out_sum, out_ovf and out_beats are stable while out_valid && !out_ready.
- in_ready falls in the same cycle that out_valid && !out_ready holds. It is a combinational path from out_ready.
- With in_valid=0, the pipeline drains. The accumulator holds its partial sum indefinitely until more beats arrive.

## Structure
- Package vecmac_pkg:
  - lane_cnt_max = 64
  - function for tree width TW
  - saturation max/min constant functions, parametrised by width and signedness
- Sub-module adder_tree_level, one per level via generate loop:
  - params N_IN, W, SIGNED
  - one registered pairwise-add level with enable
  - output width W+1
- Top holds: extension, the valid/last shift chain, the accumulator/counter/ovf logic, and the output register with adv.

## Test plan
- LANES=4, SIGNED=0: one beat {1,2,3,4} with last → out_sum=10, out_beats=1, out_ovf=0, out_valid exactly 3 cycles after the beat is accepted.
- LANES=4, SIGNED=1: beats {-1,-1,-1,-1}, then {100,0,0,0} with last → out_sum=96, out_beats=2.
- ACCW=TW+1, SAT=1, SIGNED=1: repeated max-positive beats → out_sum clamps to 2^(ACCW-1)-1, out_ovf=1. Same test with SAT=0 → wrapped value, out_ovf=1.
- Back-pressure: out_ready=0 for 5 cycles with a continuous input stream → in_ready=0 during the stall, output held, no beats lost. Subsequent results match the model in order.
- flush in the middle of a 3-beat vector → no result for that vector. The next single-beat vector {5,5,5,5} → out_sum=20, out_beats=1.
- LANES=1 and LANES=64, random 1..8-beat vectors with random out_ready → scoreboard exact match. Latency is 2 cycles for LANES=1 and 7 cycles for LANES=64.

Source files
------------

// File: rtl/vecmac_pkg.sv
// Shared constants and helpers for the int8 vector-MAC datapath: tree width
// and saturation limits as constant functions.
package vecmac_pkg;

    localparam int lane_cnt_max = 64;
    localparam int SAT_W_MAX    = 128;

    function automatic int tree_width(input int inw, input int lanes);
        return inw + $clog2(lanes);
    endfunction

    function automatic logic [SAT_W_MAX-1:0] sat_max(input int w, input bit is_signed);
        logic [SAT_W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_W_MAX; i++) begin
            if (i < w) v[i] = 1'b1;
        end
        if (is_signed) v[w-1] = 1'b0;
        return v;
    endfunction

    function automatic logic [SAT_W_MAX-1:0] sat_min(input int w, input bit is_signed);
        logic [SAT_W_MAX-1:0] v;
        v = '0;
        if (is_signed) v[w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level of the reduction tree; each output is one
// bit wider than its inputs so no carry is ever dropped.
module adder_tree_level #(
    parameter int N_IN   = 2,
    parameter int W      = 16,
    parameter int SIGNED = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_en,
    input  logic [N_IN*W-1:0]           i_data,
    output logic [(N_IN/2)*(W+1)-1:0]   o_data
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*(W+1)-1:0] w_sum;
    logic [N_OUT*(W+1)-1:0] r_sum;

    function automatic logic [W:0] ext(input logic [W-1:0] v);
        return (SIGNED != 0) ? {v[W-1], v} : {1'b0, v};
    endfunction

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_sum[j*(W+1) +: (W+1)] = ext(i_data[(2*j)*W +: W]) + ext(i_data[(2*j+1)*W +: W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= w_sum;
        end
    end

    assign o_data = r_sum;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined LANES-wide adder tree feeding a beat accumulator; emits one dot
// product per vector with overflow flag and beat count, under a global stall.
module adder_tree_acc
    import vecmac_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int INW    = 16,
    parameter int SIGNED = 1,
    parameter int SAT    = 0,
    parameter int ACCW   = INW + $clog2(LANES) + 8,
    parameter int CNTW   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [LANES*INW-1:0]  prod_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       out_sum,
    output logic                  out_ovf,
    output logic [CNTW-1:0]       out_beats
);

    localparam int D  = $clog2(LANES);
    localparam int TS = (D == 0) ? 1 : D;
    localparam int TW = tree_width(INW, LANES);
    localparam logic [SAT_W_MAX-1:0] LP_MAX = sat_max(ACCW, SIGNED != 0);
    localparam logic [SAT_W_MAX-1:0] LP_MIN = sat_min(ACCW, SIGNED != 0);

    if (LANES < 1 || LANES > lane_cnt_max || (LANES & (LANES - 1)) != 0 || ACCW < TW) begin : g_bad_cfg
        $error("adder_tree_acc: LANES must be a power of 2 in 1..%0d and ACCW >= TW", lane_cnt_max);
    end

    logic            w_adv;
    logic [TW-1:0]   w_tree;
    logic [TS-1:0]   r_vld;
    logic [TS-1:0]   r_lst;
    logic            w_beat;
    logic            w_last;

    logic [ACCW-1:0] r_acc;
    logic [CNTW-1:0] r_cnt;
    logic            r_ovf;
    logic            r_acc_empty;
    logic            r_out_valid;
    logic [ACCW-1:0] r_out_sum;
    logic            r_out_ovf;
    logic [CNTW-1:0] r_out_beats;

    logic [ACCW-1:0] w_ext;
    logic [ACCW-1:0] w_base;
    logic [ACCW:0]   w_sum;
    logic            w_ovf;
    logic [ACCW-1:0] w_new;
    logic [CNTW-1:0] w_cnt_new;
    logic            w_ovf_new;

    // The whole datapath freezes while a finished result waits downstream.
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    if (D == 0) begin : g_pass
        logic [TW-1:0] r_pass;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pass <= '0;
            end else if (w_adv) begin
                r_pass <= prod_flat;
            end
        end
        assign w_tree = r_pass;
    end else begin : g_tree
        for (genvar k = 0; k < D; k++) begin : g_lvl
            localparam int N_IN = LANES >> k;
            localparam int W    = INW + k;
            logic [N_IN*W-1:0]          w_in;
            logic [(N_IN/2)*(W+1)-1:0]  w_out;
            if (k == 0) begin : g_first
                assign w_in = prod_flat;
            end else begin : g_next
                assign w_in = g_lvl[k-1].w_out;
            end
            adder_tree_level #(.N_IN(N_IN), .W(W), .SIGNED(SIGNED)) u_lvl (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_adv),
                .i_data (w_in),
                .o_data (w_out)
            );
        end
        assign w_tree = g_lvl[D-1].w_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (flush) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_lst[0] <= in_last;
            for (int i = 1; i < TS; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
        end
    end

    assign w_beat = r_vld[TS-1];
    assign w_last = r_lst[TS-1];
    assign w_base = r_acc_empty ? '0 : r_acc;

    // Overflow is judged one bit wider than the accumulator.
    if (SIGNED != 0) begin : g_signed
        assign w_ext = ACCW'($signed(w_tree));
        assign w_sum = (ACCW+1)'($signed(w_base)) + (ACCW+1)'($signed(w_ext));
        assign w_ovf = w_sum[ACCW] ^ w_sum[ACCW-1];
    end else begin : g_unsigned
        assign w_ext = ACCW'(w_tree);
        assign w_sum = {1'b0, w_base} + {1'b0, w_ext};
        assign w_ovf = w_sum[ACCW];
    end

    always_comb begin
        w_new = w_sum[ACCW-1:0];
        if (w_ovf && SAT != 0) begin
            if (SIGNED != 0 && w_sum[ACCW]) w_new = LP_MIN[ACCW-1:0];
            else                            w_new = LP_MAX[ACCW-1:0];
        end
    end

    assign w_cnt_new = r_acc_empty ? CNTW'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNTW'(1));
    assign w_ovf_new = (!r_acc_empty && r_ovf) || w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_acc_empty <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_beats <= '0;
        end else if (flush) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_acc_empty <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_beat && w_last;
            if (w_beat) begin
                if (w_last) begin
                    r_out_sum   <= w_new;
                    r_out_ovf   <= w_ovf_new;
                    r_out_beats <= w_cnt_new;
                    r_acc_empty <= 1'b1;
                end else begin
                    r_acc       <= w_new;
                    r_cnt       <= w_cnt_new;
                    r_ovf       <= w_ovf_new;
                    r_acc_empty <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign out_beats = r_out_beats;

endmodule
